fault_trip_ctrl: RTL and testbench
==================================

# fault_trip_ctrl

Protection controller directly downstream of the per-channel `err_high_detect` fault filters in the IGBT power unit. It consumes their latched fault levels and forces PWM gate blocking within one clock of any enabled fault. It records first-fault and accumulated-fault diagnostics and enforces a minimum lockout time. It then clears the detectors with a timed `reset_unit` pulse on host request and verifies the faults are gone before re-enabling the gates.

## Interface
Parameters:
- N_FAULT, 8, number of fault channels (1..15)
- HOLD_US, 1000, minimum lockout in µs before a clear request is accepted (≥1)
- RST_PULSE_CLKS, 4, width of the `reset_unit` pulse in clocks (≥1)
- VERIFY_CLKS, 2, settle window after `reset_unit` before re-checking faults (≥1)

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- time_1us, in, 1, shared 1 µs strobe, treated as asynchronous
- fault_in, in, N_FAULT, latched fault levels from the detectors (1 = fault)
- fault_mask, in, N_FAULT, per-channel enable (1 = channel can trip)
- reset_req, in, 1, host clear request, level; only its rising edge is used
- reset_unit, out, 1, clear pulse to all detectors
- pwm_block, out, 1, 1 = all gates forced off
- fault_vec, out, N_FAULT, OR of masked faults seen since the last trip entry
- first_fault, out, 4, index+1 of the lowest-index masked fault at trip; 0 = none
- trip_cnt, out, 16, saturating count of trips out of RUN
- state, out, 2, current FSM state (RUN=0, LOCK=1, CLEAR=2, VERIFY=3)

## Operation
- `act` = `fault_in & fault_mask`. `any` = OR-reduction of `act`.
- Tick: `time_1us` passes through a 2-flop synchronizer. A tick is the synchronized 1→0 transition, one clock wide.
- `reset_req` is registered once. `req_edge` = the registered value was 0 and the input is now 1.
- RUN:
  - `pwm_block`=0.
  - If `any`, go to LOCK.
  - On the same edge: `pwm_block`←1, `fault_vec`←`act`, `first_fault`←lowest set index+1, `hold_cnt`←0, `trip_cnt`←`trip_cnt`+1, saturating at 0xFFFF.
- LOCK:
  - `pwm_block`=1. `fault_vec` |= `act` every cycle.
  - `hold_cnt` increments on each tick and saturates at HOLD_US. Its width is $clog2(HOLD_US+1).
  - If `req_edge` and `hold_cnt`≥HOLD_US, go to CLEAR. Otherwise `req_edge` is discarded and not remembered.
- CLEAR:
  - `reset_unit`=1 for exactly RST_PULSE_CLKS clocks, then go to VERIFY.
  - `pwm_block` stays 1.
- VERIFY:
  - `reset_unit`=0 and `pwm_block`=1 for VERIFY_CLKS clocks.
  - At the end of the window: if `any`, go to LOCK with `hold_cnt`←0. In that case `trip_cnt` and `first_fault` are unchanged and `fault_vec` |= `act`.
  - Otherwise go to RUN with `pwm_block`←0.
- `first_fault` and `fault_vec` hold their values through the return to RUN. They are overwritten only at the next RUN→LOCK trip.
- `fault_mask` changes take effect immediately for trip detection. Clearing a mask bit never releases `pwm_block` outside the VERIFY→RUN path.

## Timing
- Reset values:
  - state=LOCK, `pwm_block`=1, `hold_cnt`=HOLD_US (lockout already satisfied), `reset_unit`=0.
  - `fault_vec`=0, `first_fault`=0, `trip_cnt`=0, synchronizers=0.
  - Power-up therefore needs one host clear before the gates run.
- Trip latency: `fault_in` high at edge k means `pwm_block`=1 after edge k. That is one clock, with registered outputs only.
- Clear latency with lockout satisfied:
  - `req_edge` at edge k: `reset_unit` high for edges k+1..k+RST_PULSE_CLKS.
  - `pwm_block` falls at edge k+RST_PULSE_CLKS+VERIFY_CLKS+1 if `any`=0.
- Tick latency: 3 clocks from the `time_1us` falling edge to the `hold_cnt` increment.
- Simultaneous `req_edge` and tick in LOCK: compare against `hold_cnt` before the increment.
- Faults arriving during CLEAR are ignored by the FSM but OR into `fault_vec`. Detection happens in VERIFY.
- Asynchronous reset mid-CLEAR: `reset_unit` drops immediately and the FSM returns to the reset state.

## Structure
- Package `fault_trip_pkg`: the state enum (RUN/LOCK/CLEAR/VERIFY with the encoding above) and the `first_fault` width constant (4).
- Sub-module `us_tick_sync`: 2-flop synchronizer plus falling-edge detector producing a one-clock tick. It is reusable by the detectors.
- Lowest-index priority encoder: a function in the package.

## Test plan
- Post-reset: `pwm_block`=1 and state=1. A `reset_req` rise gives `reset_unit` high for 4 clocks, then `pwm_block`=0 at 7 clocks after the edge, and state=0.
- RUN with `fault_in`=0x24 and mask=0xFF: `pwm_block`=1 next clock, `first_fault`=3, `fault_vec`=0x24, `trip_cnt`=1.
- HOLD_US=10: `reset_req` after 5 ticks is ignored (no `reset_unit`). A second `reset_req` after 10 ticks is accepted.
- Fault persists through VERIFY: state returns to LOCK, `hold_cnt` restarts from 0, `trip_cnt` stays 1, `first_fault` unchanged.
- `fault_in`=0x01 with mask=0xFE: no trip. Setting mask bit 0 causes a trip the next clock with `first_fault`=1.
- `trip_cnt` preloaded near saturation: after 2 more trips it reads 0xFFFF and stays there.

Source files
------------

// File: rtl/fault_trip_pkg.sv
// fault_trip_pkg: shared state encoding, first-fault width and lowest-index encoder
package fault_trip_pkg;
  localparam int FF_W = 4;
  typedef enum logic [1:0] {RUN = 2'd0, LOCK = 2'd1, CLEAR = 2'd2, VERIFY = 2'd3} state_t;
  function automatic logic [FF_W-1:0] lowest_idx(input logic [14:0] v);
    lowest_idx = '0;
    for (int i = 14; i >= 0; i--) if (v[i]) lowest_idx = FF_W'(i + 1);
  endfunction
endpackage

// File: rtl/us_tick_sync.sv
// us_tick_sync: synchronizes the async 1 us strobe and emits a one-clock tick on its falling edge
module us_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic time_1us,
  output logic tick
);
  logic s1, s2, s3;
  // two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {time_1us, s1, s2};
  assign tick = s3 & ~s2;
endmodule

// File: rtl/fault_trip_ctrl.sv
// fault_trip_ctrl: trips PWM blocking on masked faults, enforces lockout and timed detector clear
module fault_trip_ctrl
  import fault_trip_pkg::*;
#(
  parameter int N_FAULT        = 8,
  parameter int HOLD_US        = 1000,
  parameter int RST_PULSE_CLKS = 4,
  parameter int VERIFY_CLKS    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               time_1us,
  input  logic [N_FAULT-1:0] fault_in,
  input  logic [N_FAULT-1:0] fault_mask,
  input  logic               reset_req,
  output logic               reset_unit,
  output logic               pwm_block,
  output logic [N_FAULT-1:0] fault_vec,
  output logic [FF_W-1:0]    first_fault,
  output logic [15:0]        trip_cnt,
  output logic [1:0]         state
);
  localparam int HW = $clog2(HOLD_US + 1);
  localparam int PMAX = RST_PULSE_CLKS > VERIFY_CLKS ? RST_PULSE_CLKS : VERIFY_CLKS;
  localparam int PW = $clog2(PMAX + 1);
  state_t st, st_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [PW-1:0] cnt, cnt_d;
  logic [N_FAULT-1:0] act, fv_d;
  logic [14:0] act_w;
  logic [FF_W-1:0] ff_d;
  logic [15:0] tc_d;
  logic any, tick, req_q, req_edge, pwm_d, ru_d;
  us_tick_sync u_tick (.clk(clk), .rst_n(rst_n), .time_1us(time_1us), .tick(tick));
  assign act = fault_in & fault_mask;
  assign any = |act;
  assign req_edge = reset_req & ~req_q;
  assign state = st;
  // widen the active vector to the encoder's fixed width
  always_comb begin
    act_w = '0;
    act_w[N_FAULT-1:0] = act;
  end
  // next-state and next-output logic for the protection FSM
  always_comb begin
    st_d = st;
    cnt_d = cnt;
    hold_d = hold_cnt;
    pwm_d = pwm_block;
    ru_d = reset_unit;
    fv_d = fault_vec | act;
    ff_d = first_fault;
    tc_d = trip_cnt;
    case (st)
      RUN: begin
        pwm_d = any;
        fv_d = any ? act : fault_vec;
        if (any) begin
          st_d = LOCK;
          ff_d = lowest_idx(act_w);
          hold_d = '0;
          tc_d = trip_cnt == 16'hFFFF ? trip_cnt : trip_cnt + 16'd1;
        end
      end
      LOCK: begin
        pwm_d = 1'b1;
        if (tick && hold_cnt < HW'(HOLD_US)) hold_d = hold_cnt + HW'(1);
        if (req_edge && hold_cnt >= HW'(HOLD_US)) begin
          st_d = CLEAR;
          ru_d = 1'b1;
          cnt_d = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt + PW'(1);
        if (cnt == PW'(RST_PULSE_CLKS - 1)) begin
          st_d = VERIFY;
          ru_d = 1'b0;
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d = cnt + PW'(1);
        if (cnt == PW'(VERIFY_CLKS - 1)) begin
          cnt_d = '0;
          st_d = any ? LOCK : RUN;
          pwm_d = any;
          hold_d = any ? '0 : hold_cnt;
        end
      end
    endcase
  end
  // state and registered outputs; reset lands in LOCK with lockout already served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= LOCK;
      cnt <= '0;
      hold_cnt <= HW'(HOLD_US);
      pwm_block <= 1'b1;
      reset_unit <= 1'b0;
      fault_vec <= '0;
      first_fault <= '0;
      trip_cnt <= '0;
      req_q <= 1'b0;
    end else begin
      st <= st_d;
      cnt <= cnt_d;
      hold_cnt <= hold_d;
      pwm_block <= pwm_d;
      reset_unit <= ru_d;
      fault_vec <= fv_d;
      first_fault <= ff_d;
      trip_cnt <= tc_d;
      req_q <= reset_req;
    end
endmodule

// File: tb/tb_fault_trip_ctrl.sv
// tb_fault_trip_ctrl: directed self-checking bench for the fault trip controller
module tb_fault_trip_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, time_1us = 1'b0, reset_req = 1'b0;
  logic [7:0] fault_in = '0, fault_mask = '0, fault_vec;
  logic reset_unit, pwm_block;
  logic [3:0] first_fault;
  logic [15:0] trip_cnt;
  logic [1:0] state;
  int passed = 0, total = 0;
  fault_trip_ctrl #(.N_FAULT(8), .HOLD_US(10), .RST_PULSE_CLKS(4), .VERIFY_CLKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .time_1us(time_1us), .fault_in(fault_in), .fault_mask(fault_mask),
    .reset_req(reset_req), .reset_unit(reset_unit), .pwm_block(pwm_block), .fault_vec(fault_vec),
    .first_fault(first_fault), .trip_cnt(trip_cnt), .state(state)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic us_tick();
    time_1us = 1'b1;
    step(2);
    time_1us = 1'b0;
    step(4);
  endtask
  task automatic do_clear();
    fault_in = '0;
    repeat (10) us_tick();
    reset_req = 1'b1;
    step(7);
    reset_req = 1'b0;
    step(1);
  endtask
  initial begin
    step(2);
    chk("rst_pwm", 32'(pwm_block), 1);
    chk("rst_state", 32'(state), 1);
    chk("rst_ru", 32'(reset_unit), 0);
    chk("rst_trip", 32'(trip_cnt), 0);
    chk("rst_ff", 32'(first_fault), 0);
    chk("rst_fv", 32'(fault_vec), 0);
    rst_n = 1'b1;
    fault_mask = 8'hFF;
    step(1);
    reset_req = 1'b1;
    step(1);
    chk("pu_ru_on", 32'(reset_unit), 1);
    chk("pu_state_clr", 32'(state), 2);
    step(3);
    chk("pu_ru_last", 32'(reset_unit), 1);
    step(1);
    chk("pu_ru_off", 32'(reset_unit), 0);
    chk("pu_state_ver", 32'(state), 3);
    step(1);
    chk("pu_pwm_ver", 32'(pwm_block), 1);
    step(1);
    chk("pu_pwm_run", 32'(pwm_block), 0);
    chk("pu_state_run", 32'(state), 0);
    reset_req = 1'b0;
    step(2);
    fault_in = 8'h24;
    step(1);
    chk("trip_pwm", 32'(pwm_block), 1);
    chk("trip_state", 32'(state), 1);
    chk("trip_ff", 32'(first_fault), 3);
    chk("trip_fv", 32'(fault_vec), 32'h24);
    chk("trip_cnt1", 32'(trip_cnt), 1);
    chk("trip_hold0", 32'(dut.hold_cnt), 0);
    fault_in = 8'h25;
    step(1);
    chk("lock_fv_or", 32'(fault_vec), 32'h25);
    fault_in = 8'h24;
    repeat (5) us_tick();
    chk("hold5", 32'(dut.hold_cnt), 5);
    reset_req = 1'b1;
    step(1);
    chk("early_req_ru", 32'(reset_unit), 0);
    chk("early_req_state", 32'(state), 1);
    reset_req = 1'b0;
    step(1);
    repeat (7) us_tick();
    chk("hold_sat", 32'(dut.hold_cnt), 10);
    reset_req = 1'b1;
    step(1);
    chk("req_ok_ru", 32'(reset_unit), 1);
    chk("req_ok_state", 32'(state), 2);
    reset_req = 1'b0;
    fault_in = 8'hA4;
    step(1);
    chk("clr_fv_or", 32'(fault_vec), 32'hA5);
    chk("clr_ignores", 32'(state), 2);
    step(5);
    chk("ver_relock", 32'(state), 1);
    chk("ver_hold0", 32'(dut.hold_cnt), 0);
    chk("ver_trip", 32'(trip_cnt), 1);
    chk("ver_ff", 32'(first_fault), 3);
    chk("ver_pwm", 32'(pwm_block), 1);
    do_clear();
    chk("clr2_state", 32'(state), 0);
    chk("clr2_pwm", 32'(pwm_block), 0);
    chk("hold_ff", 32'(first_fault), 3);
    chk("hold_fv", 32'(fault_vec), 32'hA5);
    fault_mask = 8'hFE;
    fault_in = 8'h01;
    step(2);
    chk("masked_pwm", 32'(pwm_block), 0);
    chk("masked_state", 32'(state), 0);
    fault_mask = 8'hFF;
    step(1);
    chk("unmask_pwm", 32'(pwm_block), 1);
    chk("unmask_ff", 32'(first_fault), 1);
    chk("unmask_fv", 32'(fault_vec), 32'h01);
    chk("unmask_trip", 32'(trip_cnt), 2);
    fault_mask = 8'h00;
    step(2);
    chk("mask_off_pwm", 32'(pwm_block), 1);
    chk("mask_off_state", 32'(state), 1);
    fault_mask = 8'hFF;
    force dut.trip_cnt = 16'hFFFE;
    step(1);
    release dut.trip_cnt;
    do_clear();
    fault_in = 8'h80;
    step(1);
    chk("sat1_trip", 32'(trip_cnt), 32'hFFFF);
    chk("sat1_ff", 32'(first_fault), 8);
    do_clear();
    fault_in = 8'h10;
    step(1);
    chk("sat2_trip", 32'(trip_cnt), 32'hFFFF);
    chk("sat2_ff", 32'(first_fault), 5);
    fault_in = '0;
    repeat (10) us_tick();
    reset_req = 1'b1;
    step(2);
    chk("mid_clr_ru", 32'(reset_unit), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ru", 32'(reset_unit), 0);
    chk("arst_state", 32'(state), 1);
    chk("arst_pwm", 32'(pwm_block), 1);
    chk("arst_trip", 32'(trip_cnt), 0);
    rst_n = 1'b1;
    reset_req = 1'b0;
    step(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
